tt_um_waves: RTL and testbench
==============================

TT_UM_WAVES -- requirements
Module: tt_um_waves

Interface
REQ-001: clk  input  1  single system clock; all state updates on the rising edge.
REQ-002: rst_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-003: ena  input  1  design-enable strap; ignored, and the block runs whenever rst_n=1.
REQ-004: ui_in  input  8  [2:0] = waveform select WSEL; [7:3] = prescaler divider DIV (0..31).
REQ-005: uio_in  input  8  PARAM byte, used as PWM duty (WSEL=5) or DC level (WSEL=7).
REQ-006: uo_out  output  8  registered unsigned 8-bit waveform sample.
REQ-007: uio_out  output  8  constant 8'h00.
REQ-008: uio_oe  output  8  constant 8'h00, so all uio pins are inputs.

Function
REQ-009: State: 5-bit prescaler counter CNT; 8-bit phase PH; 8-bit LFSR; 8-bit output register OUT driving uo_out.
REQ-010: Prescaler: TICK = (CNT >= DIV).
  - On TICK: CNT<=0.
  - Otherwise: CNT<=CNT+1.
  - DIV=0 gives a tick on every clock.
  - Phase step period = DIV+1 clocks.
  - A DIV lowered below the current CNT yields a tick on the next edge (no 32-cycle wrap).
REQ-011: On TICK: PH<=PH+1, wrapping 255->0.
REQ-012: On TICK: LFSR shifts left; new bit0 = b7^b5^b4^b3 (x^8+x^6+x^5+x^4+1, maximal length 255); the all-zero state is never reached from the seed.
REQ-013: Every clock, OUT<=WAVE(WSEL, PH, LFSR, PARAM), using pre-edge values, so uo_out lags PH by one clock.
REQ-014: WSEL=0 sawtooth: PH.
REQ-015: WSEL=1 square: 8'hFF if PH[7]=0, else 8'h00.
REQ-016: WSEL=2 triangle:
  - PH[7]=0: {PH[6:0],1'b0}.
  - Otherwise: ~{PH[6:0],1'b0}.
  - Range 0..254 rising, then 255..1 falling.
REQ-017: WSEL=3 sine: round(127.5 + 127.5*sin(2*pi*PH/256)), clamped to 0..255.
  - Implemented as a 64-entry quarter-wave table with mirror/negate symmetry.
  - Required values: PH=0 ->128, PH=64 ->255, PH=128 ->128, PH=192 ->0.
REQ-018: WSEL=4 noise: LFSR value.
REQ-019: WSEL=5 PWM: 8'hFF if PH < PARAM, else 8'h00; PARAM=0 gives a constant 0.
REQ-020: WSEL=6 inverted sawtooth: ~PH.
REQ-021: WSEL=7 DC: PARAM.
REQ-022: A WSEL or DIV change takes effect on the next clock edge; PH, CNT and LFSR are not disturbed by a WSEL change.
REQ-023: No combinational path from any input to uo_out; uo_out changes only on clk edges or reset.

Reset
REQ-024: While rst_n=0, asynchronously: CNT=0, PH=0, LFSR=8'h01, OUT=8'h00.
REQ-025: Assertion mid-operation forces these values immediately, regardless of clk.
REQ-026: The first rising edge after deassertion is a normal operating edge, so with DIV=0 it sets PH=1 and OUT=WAVE(PH=0).

Verification
REQ-027: Sawtooth baseline.
  - Stimulus: ui_in=0, uio_in=0; reset low, release; count N rising edges.
  - Response: uo_out=0 during reset; after edge N>=1, uo_out=(N-1) mod 256; edge 256 gives 255, edge 257 gives 0.
REQ-028: Prescaler.
  - Stimulus: ui_in=8'b00011_000 (DIV=3, sawtooth).
  - Response: uo_out increments by 1 every 4 clocks, and each value holds 4 clocks.
REQ-029: Square and triangle.
  - Stimulus: WSEL=1, DIV=0.
  - Response: uo_out = 8'hFF for 128 clocks, then 8'h00 for 128 clocks.
  - Stimulus: WSEL=2.
  - Response: samples for PH=0,1,127,128,255 are 0,2,254,255,1.
REQ-030: Sine.
  - Stimulus: WSEL=3, DIV=0, sweep a full period.
  - Response: samples for PH=0/64/128/192 are 128/255/128/0; the sequence is monotonic between the extremes.
REQ-031: Noise.
  - Stimulus: WSEL=4, DIV=0, from reset.
  - Response: first samples 8'h01, 8'h02, 8'h04; the sequence repeats with period exactly 255 and never shows 8'h00.
REQ-032: PWM, DC and reset mid-run.
  - Stimulus: WSEL=5, uio_in=64.
  - Response: 64 clocks at FF, 192 at 00 per period.
  - Stimulus: WSEL=7, uio_in=8'hA5.
  - Response: uo_out=8'hA5 after one edge.
  - Stimulus: rst_n pulsed low between edges.
  - Response: uo_out=0 immediately; uio_out=uio_oe=0 throughout.

Source files
------------

// File: rtl/tt_um_waves.sv
// rtl/tt_um_waves.sv - prescaled phase accumulator driving an 8-waveform sample generator
module tt_um_waves (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // First quadrant of round(127.5 + 127.5*sin(2*pi*k/256)), k = 0..63
    localparam logic [7:0] SINE_TAB [64] = '{
        8'd128, 8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149,
        8'd152, 8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173,
        8'd176, 8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196,
        8'd198, 8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215,
        8'd218, 8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232,
        8'd234, 8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244,
        8'd245, 8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255
    };

    logic [2:0] wsel;
    logic [4:0] div;
    logic [7:0] param;
    logic [4:0] cnt;
    logic [7:0] ph;
    logic [7:0] lfsr;
    logic [7:0] out_q;
    logic       tick;
    logic [5:0] sin_idx;
    logic [7:0] sin_pos;
    logic [7:0] sin_val;
    logic [7:0] wave;
    logic       unused;

    assign wsel    = ui_in[2:0];
    assign div     = ui_in[7:3];
    assign param   = uio_in;
    assign tick    = (cnt >= div);
    assign uo_out  = out_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
    assign unused  = ena;

    // Odd quadrants read the table backwards; their first entry (k=64) is the peak itself.
    // The lower half negates, except at PH=128 where the exact midpoint rounds to 128.
    always_comb begin
        sin_idx = ph[6] ? 6'(6'd0 - ph[5:0]) : ph[5:0];
        sin_pos = (ph[6] && (ph[5:0] == 6'd0)) ? 8'd255 : SINE_TAB[sin_idx];
        sin_val = sin_pos;
        if (ph[7])
            sin_val = (ph[6:0] == 7'd0) ? 8'd128 : 8'(8'd255 - sin_pos);
    end

    always_comb begin
        wave = ph;
        case (wsel)
            3'd0: wave = ph;
            3'd1: wave = ph[7] ? 8'h00 : 8'hFF;
            3'd2: wave = ph[7] ? ~{ph[6:0], 1'b0} : {ph[6:0], 1'b0};
            3'd3: wave = sin_val;
            3'd4: wave = lfsr;
            3'd5: wave = (ph < param) ? 8'hFF : 8'h00;
            3'd6: wave = ~ph;
            3'd7: wave = param;
            default: wave = ph;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 5'd0;
            ph    <= 8'd0;
            lfsr  <= 8'h01;
            out_q <= 8'h00;
        end else begin
            out_q <= wave;
            if (tick) begin
                cnt  <= 5'd0;
                ph   <= ph + 8'd1;
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end else begin
                cnt  <= cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_waves.sv
// tb/tb_tt_um_waves.sv - directed self-checking bench for tt_um_waves
module tb_tt_um_waves;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    tt_um_waves dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] samp [256];
    logic [7:0] m;
    logic [7:0] exp_v;
    logic [7:0] p;
    logic       ok;
    int         n_ff;

    initial begin
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;

        // Reset state
        step();
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);

        // Sawtooth: after edge N, (N-1) mod 256
        do_reset();
        for (int n = 1; n <= 257; n++) begin
            step();
            check($sformatf("saw_edge%0d", n), uo_out, 8'((n - 1) % 256));
        end

        // Prescaler DIV=3: each value held 4 clocks
        ui_in = 8'b00011_000;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            step();
            check($sformatf("presc_edge%0d", n), uo_out, 8'((n - 1) / 4));
        end

        // DIV lowered below CNT ticks on next edge; WSEL change keeps phase
        ui_in = {5'd20, 3'd0};
        do_reset();
        repeat (10) step();
        check("div_hold", uo_out, 8'h00);
        ui_in = {5'd2, 3'd0};
        step();
        step();
        check("div_lowered", uo_out, 8'h01);
        ui_in = {5'd2, 3'd6};
        step();
        check("wsel_switch_a", uo_out, 8'hFE);
        step();
        step();
        check("wsel_switch_b", uo_out, 8'hFD);

        // Square
        ui_in = {5'd0, 3'd1};
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            step();
            check($sformatf("square_ph%0d", n - 1), uo_out, (n <= 128) ? 8'hFF : 8'h00);
        end

        // Triangle
        ui_in = {5'd0, 3'd2};
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            step();
            samp[n - 1] = uo_out;
        end
        check("tri_ph0", samp[0], 8'd0);
        check("tri_ph1", samp[1], 8'd2);
        check("tri_ph127", samp[127], 8'd254);
        check("tri_ph128", samp[128], 8'd255);
        check("tri_ph255", samp[255], 8'd1);
        for (int i = 0; i < 256; i++) begin
            p = 8'(i);
            exp_v = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            check($sformatf("tri_sweep%0d", i), samp[i], exp_v);
        end

        // Sine
        ui_in = {5'd0, 3'd3};
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            step();
            samp[n - 1] = uo_out;
        end
        check("sine_ph0", samp[0], 8'd128);
        check("sine_ph64", samp[64], 8'd255);
        check("sine_ph128", samp[128], 8'd128);
        check("sine_ph192", samp[192], 8'd0);
        ok = 1'b1;
        for (int i = 0; i < 64; i++) if (samp[i + 1] < samp[i]) ok = 1'b0;
        check("sine_rise_0_64", {7'd0, ok}, 8'd1);
        ok = 1'b1;
        for (int i = 64; i < 192; i++) if (samp[i + 1] > samp[i]) ok = 1'b0;
        check("sine_fall_64_192", {7'd0, ok}, 8'd1);
        ok = 1'b1;
        for (int i = 192; i < 255; i++) if (samp[i + 1] < samp[i]) ok = 1'b0;
        if (samp[0] < samp[255]) ok = 1'b0;
        check("sine_rise_192_256", {7'd0, ok}, 8'd1);

        // Noise
        ui_in = {5'd0, 3'd4};
        do_reset();
        m = 8'h01;
        for (int n = 1; n <= 256; n++) begin
            step();
            samp[n - 1] = uo_out;
            check($sformatf("noise_s%0d", n - 1), uo_out, m);
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        end
        check("noise_first0", samp[0], 8'h01);
        check("noise_first1", samp[1], 8'h02);
        check("noise_first2", samp[2], 8'h04);
        ok = 1'b1;
        for (int i = 0; i < 256; i++) if (samp[i] == 8'h00) ok = 1'b0;
        check("noise_nonzero", {7'd0, ok}, 8'd1);
        ok = 1'b1;
        for (int i = 1; i < 255; i++) if (samp[i] == samp[0]) ok = 1'b0;
        check("noise_no_early_repeat", {7'd0, ok}, 8'd1);
        check("noise_period255", samp[255], samp[0]);

        // PWM duty 64
        ui_in  = {5'd0, 3'd5};
        uio_in = 8'd64;
        do_reset();
        n_ff = 0;
        for (int n = 1; n <= 256; n++) begin
            step();
            if (uo_out == 8'hFF) n_ff++;
            check($sformatf("pwm_ph%0d", n - 1), uo_out, (n <= 64) ? 8'hFF : 8'h00);
        end
        check("pwm_ff_count", 8'(n_ff), 8'd64);

        // PWM with PARAM=0 stays low
        uio_in = 8'd0;
        ok = 1'b1;
        step();
        for (int n = 0; n < 256; n++) begin
            step();
            if (uo_out != 8'h00) ok = 1'b0;
        end
        check("pwm_zero_duty", {7'd0, ok}, 8'd1);

        // DC
        ui_in  = {5'd0, 3'd7};
        uio_in = 8'hA5;
        step();
        check("dc_a5", uo_out, 8'hA5);
        check("dc_uio_out", uio_out, 8'h00);
        check("dc_uio_oe", uio_oe, 8'h00);

        // Reset mid-run, between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_uo_out", uo_out, 8'h00);
        check("midrun_reset_uio_out", uio_out, 8'h00);
        check("midrun_reset_uio_oe", uio_oe, 8'h00);
        step();
        ui_in = {5'd0, 3'd0};
        rst_n = 1'b1;
        step();
        check("post_reset_edge1", uo_out, 8'h00);
        step();
        check("post_reset_edge2", uo_out, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
